// File: rtl/ddr_wr_arbiter.sv
// ddr_wr_arbiter: round-robin arbiter that shares one DDR3 AXI write port between two burst writers
// Ports:
//   core_clk, core_rst_n   clock and asynchronous active-low reset
//   init_calib_complete    DDR3 calibrated; no grant is issued while low
//   m0_* / m1_*            AXI write slave ports (0 = send-buffer manager, 1 = receive-buffer manager)
//   s_axi_*                AXI write master port towards the DDR3 memory controller
//   err_o                  sticky protocol error (misplaced wlast, bad bresp, bid not matching grant)
module ddr_wr_arbiter #(
    parameter int C_S_AXI_ID_WIDTH   = 4,
    parameter int C_S_AXI_DATA_WIDTH = 512,
    parameter int C_S_AXI_ADDR_WIDTH = 32
) (
    input  logic                              core_clk,
    input  logic                              core_rst_n,
    input  logic                              init_calib_complete,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     m0_awaddr,
    input  logic [7:0]                        m0_awlen,
    input  logic                              m0_awvalid,
    output logic                              m0_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     m0_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   m0_wstrb,
    input  logic                              m0_wlast,
    input  logic                              m0_wvalid,
    output logic                              m0_wready,
    output logic                              m0_bvalid,
    output logic [1:0]                        m0_bresp,
    input  logic                              m0_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     m1_awaddr,
    input  logic [7:0]                        m1_awlen,
    input  logic                              m1_awvalid,
    output logic                              m1_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     m1_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   m1_wstrb,
    input  logic                              m1_wlast,
    input  logic                              m1_wvalid,
    output logic                              m1_wready,
    output logic                              m1_bvalid,
    output logic [1:0]                        m1_bresp,
    input  logic                              m1_bready,
    output logic [C_S_AXI_ID_WIDTH-1:0]       s_axi_awid,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
    output logic [7:0]                        s_axi_awlen,
    output logic [2:0]                        s_axi_awsize,
    output logic [1:0]                        s_axi_awburst,
    output logic                              s_axi_awlock,
    output logic [3:0]                        s_axi_awcache,
    output logic [2:0]                        s_axi_awprot,
    output logic [3:0]                        s_axi_awqos,
    output logic                              s_axi_awvalid,
    input  logic                              s_axi_awready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_wdata,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
    output logic                              s_axi_wlast,
    output logic                              s_axi_wvalid,
    input  logic                              s_axi_wready,
    output logic                              s_axi_bready,
    input  logic [C_S_AXI_ID_WIDTH-1:0]       s_axi_bid,
    input  logic [1:0]                        s_axi_bresp,
    input  logic                              s_axi_bvalid,
    output logic                              err_o
);
    localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t      r_state, w_state_nxt;
    logic        r_gnt, r_last_gnt, r_err, w_gnt_nxt, w_err_set;
    logic [7:0]  r_len, r_beat, w_awlen_sel;
    logic        w_in_addr, w_in_data, w_in_resp;
    logic        w_aw_hs, w_w_hs, w_b_hs;
    logic        w_wvalid_sel, w_wlast_sel, w_bready_sel;

    assign w_in_addr    = (r_state == ADDR);
    assign w_in_data    = (r_state == DATA);
    assign w_in_resp    = (r_state == RESP);
    assign w_awlen_sel  = r_gnt ? m1_awlen  : m0_awlen;
    assign w_wvalid_sel = r_gnt ? m1_wvalid : m0_wvalid;
    assign w_wlast_sel  = r_gnt ? m1_wlast  : m0_wlast;
    assign w_bready_sel = r_gnt ? m1_bready : m0_bready;

    assign s_axi_awid    = C_S_AXI_ID_WIDTH'(r_gnt);
    assign s_axi_awaddr  = r_gnt ? m1_awaddr : m0_awaddr;
    assign s_axi_awlen   = w_awlen_sel;
    assign s_axi_awsize  = 3'($clog2(STRB_W));
    assign s_axi_awburst = 2'b01;
    assign s_axi_awlock  = 1'b0;
    assign s_axi_awcache = 4'b0011;
    assign s_axi_awprot  = 3'b000;
    assign s_axi_awqos   = 4'b0000;
    // Valids depend only on registered state and requester valids, never on s_axi_*ready
    assign s_axi_awvalid = w_in_addr;
    assign s_axi_wdata   = r_gnt ? m1_wdata : m0_wdata;
    assign s_axi_wstrb   = r_gnt ? m1_wstrb : m0_wstrb;
    assign s_axi_wlast   = w_wlast_sel;
    assign s_axi_wvalid  = w_in_data & w_wvalid_sel;
    assign s_axi_bready  = w_in_resp & w_bready_sel;

    assign m0_awready = w_in_addr & ~r_gnt & s_axi_awready;
    assign m1_awready = w_in_addr &  r_gnt & s_axi_awready;
    assign m0_wready  = w_in_data & ~r_gnt & s_axi_wready;
    assign m1_wready  = w_in_data &  r_gnt & s_axi_wready;
    assign m0_bvalid  = w_in_resp & ~r_gnt & s_axi_bvalid;
    assign m1_bvalid  = w_in_resp &  r_gnt & s_axi_bvalid;
    assign m0_bresp   = s_axi_bresp;
    assign m1_bresp   = s_axi_bresp;
    assign err_o      = r_err;

    assign w_aw_hs = s_axi_awvalid & s_axi_awready;
    assign w_w_hs  = s_axi_wvalid & s_axi_wready;
    assign w_b_hs  = s_axi_bvalid & s_axi_bready;

    // wlast must coincide exactly with the beat numbered awlen; bid must echo the grant
    assign w_err_set = (w_w_hs && (w_wlast_sel != (r_beat == r_len))) ||
                       (w_b_hs && (s_axi_bresp != 2'b00 || s_axi_bid != s_axi_awid));

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        case (r_state)
            IDLE: if (init_calib_complete && (m0_awvalid || m1_awvalid)) begin
                w_state_nxt = ADDR;
                // On a tie the requester not served last wins
                w_gnt_nxt   = (m0_awvalid && m1_awvalid) ? ~r_last_gnt : m1_awvalid;
            end
            ADDR: w_state_nxt = w_aw_hs ? DATA : ADDR;
            DATA: w_state_nxt = (w_w_hs && w_wlast_sel) ? RESP : DATA;
            RESP: w_state_nxt = w_b_hs ? IDLE : RESP;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            r_state    <= IDLE;
            r_gnt      <= 1'b1;
            r_last_gnt <= 1'b1;
            r_len      <= '0;
            r_beat     <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            if (w_aw_hs) begin
                r_len  <= w_awlen_sel;
                r_beat <= '0;
            end else if (w_w_hs) begin
                r_beat <= r_beat + 8'd1;
            end
            if (w_b_hs) r_last_gnt <= r_gnt;
            if (w_err_set) r_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ddr_wr_arbiter.sv
// tb_ddr_wr_arbiter: scoreboard bench for ddr_wr_arbiter with random requester/DDR timing
module tb_ddr_wr_arbiter;
    localparam int IDW = 4, DW = 512, AW = 32, SW = DW / 8;

    typedef struct { logic [AW-1:0] addr; logic [7:0] len; int nb; logic [1:0] bresp; int id; } burst_t;
    typedef struct { logic [DW-1:0] data; logic [SW-1:0] strb; logic last; } beat_t;
    typedef struct { logic [1:0] bresp; logic [IDW-1:0] id; } resp_t;

    logic clk = 1'b0, rst_n = 1'b0, calib = 1'b0;
    always #5 clk = ~clk;

    logic [1:0][AW-1:0] m_awaddr = '0;
    logic [1:0][7:0]    m_awlen = '0;
    logic [1:0]         m_awvalid = '0, m_wlast = '0, m_wvalid = '0, m_bready = '0;
    logic [1:0][DW-1:0] m_wdata = '0;
    logic [1:0][SW-1:0] m_wstrb = '0;
    logic [1:0]         m_awready, m_wready, m_bvalid;
    logic [1:0][1:0]    m_bresp;

    logic [IDW-1:0] s_awid, s_bid = '0;
    logic [AW-1:0]  s_awaddr;
    logic [7:0]     s_awlen;
    logic [2:0]     s_awsize, s_awprot;
    logic [1:0]     s_awburst, s_bresp = '0;
    logic [3:0]     s_awcache, s_awqos;
    logic           s_awlock, s_awvalid, s_wlast, s_wvalid, s_bready, err_o;
    logic           s_awready = 1'b0, s_wready = 1'b0, s_bvalid = 1'b0;
    logic [DW-1:0]  s_wdata;
    logic [SW-1:0]  s_wstrb;

    ddr_wr_arbiter dut (
        .core_clk(clk), .core_rst_n(rst_n), .init_calib_complete(calib),
        .m0_awaddr(m_awaddr[0]), .m0_awlen(m_awlen[0]), .m0_awvalid(m_awvalid[0]), .m0_awready(m_awready[0]),
        .m0_wdata(m_wdata[0]), .m0_wstrb(m_wstrb[0]), .m0_wlast(m_wlast[0]), .m0_wvalid(m_wvalid[0]),
        .m0_wready(m_wready[0]), .m0_bvalid(m_bvalid[0]), .m0_bresp(m_bresp[0]), .m0_bready(m_bready[0]),
        .m1_awaddr(m_awaddr[1]), .m1_awlen(m_awlen[1]), .m1_awvalid(m_awvalid[1]), .m1_awready(m_awready[1]),
        .m1_wdata(m_wdata[1]), .m1_wstrb(m_wstrb[1]), .m1_wlast(m_wlast[1]), .m1_wvalid(m_wvalid[1]),
        .m1_wready(m_wready[1]), .m1_bvalid(m_bvalid[1]), .m1_bresp(m_bresp[1]), .m1_bready(m_bready[1]),
        .s_axi_awid(s_awid), .s_axi_awaddr(s_awaddr), .s_axi_awlen(s_awlen), .s_axi_awsize(s_awsize),
        .s_axi_awburst(s_awburst), .s_axi_awlock(s_awlock), .s_axi_awcache(s_awcache), .s_axi_awprot(s_awprot),
        .s_axi_awqos(s_awqos), .s_axi_awvalid(s_awvalid), .s_axi_awready(s_awready),
        .s_axi_wdata(s_wdata), .s_axi_wstrb(s_wstrb), .s_axi_wlast(s_wlast), .s_axi_wvalid(s_wvalid),
        .s_axi_wready(s_wready), .s_axi_bready(s_bready), .s_axi_bid(s_bid), .s_axi_bresp(s_bresp),
        .s_axi_bvalid(s_bvalid), .err_o(err_o)
    );

    burst_t     st [2][$];
    burst_t     req_q [2][$];
    burst_t     exp_aw [$];
    beat_t      exp_w [$];
    logic [1:0] exp_b [2][$];
    resp_t      sl_q [$];

    int  n_cmp = 0, n_bad = 0, cyc = 0, last_srv = 1, cur_gnt = 0, leak = 0, leak_base = 0;
    int  aw_rise = -1, req_rise = -1, t_cal = 0;
    bit  err_exp = 1'b0;
    logic f_aw = 1'b0, f_w = 1'b0, f_wl = 1'b0, f_b = 1'b0, p_aw = 1'b0, p_req = 1'b0;
    logic [1:0] fm_aw = '0, fm_w = '0, fm_b = '0;

    function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a, input int b);
        return {16{a ^ (32'(b) * 32'h9E37_79B9)}};
    endfunction

    function automatic logic [SW-1:0] strb_of(input logic [AW-1:0] a, input int b);
        return {2{a + 32'(b)}};
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: samples mid-cycle, pops expectations on every handshake about to happen
    always @(negedge clk) begin : mon
        burst_t r;
        beat_t  w;
        int     g;
        f_aw  = s_awvalid && s_awready;
        f_w   = s_wvalid && s_wready;
        f_wl  = s_wlast;
        f_b   = s_bvalid && s_bready;
        fm_aw = m_awvalid & m_awready;
        fm_w  = m_wvalid & m_wready;
        fm_b  = m_bvalid & m_bready;
        if ((|m_awvalid) && !p_req) req_rise = cyc;
        if (s_awvalid && !p_aw) aw_rise = cyc;
        p_req = |m_awvalid;
        p_aw  = s_awvalid;
        g = (s_awvalid && exp_aw.size() > 0) ? exp_aw[0].id : cur_gnt;
        for (int i = 0; i < 2; i++)
            if (i != g && (m_awready[i] || m_wready[i] || m_bvalid[i])) leak++;
        if (f_aw) begin
            chk("aw_expected", exp_aw.size() != 0, 1);
            if (exp_aw.size() != 0) begin
                r = exp_aw.pop_front();
                chk("awid", s_awid, IDW'(r.id));
                chk("awaddr", s_awaddr, r.addr);
                chk("awlen", s_awlen, r.len);
                chk("aw_const", {s_awsize, s_awburst, s_awlock, s_awcache, s_awprot, s_awqos},
                    {3'd6, 2'b01, 1'b0, 4'b0011, 3'b000, 4'b0000});
                cur_gnt = r.id;
                sl_q.push_back('{r.bresp, IDW'(r.id)});
            end
        end
        if (f_w) begin
            chk("w_expected", exp_w.size() != 0, 1);
            if (exp_w.size() != 0) begin
                w = exp_w.pop_front();
                chk("wdata", s_wdata, w.data);
                chk("wstrb", s_wstrb, w.strb);
                chk("wlast", s_wlast, w.last);
            end
        end
        for (int i = 0; i < 2; i++)
            if (fm_b[i]) begin
                chk("b_expected", exp_b[i].size() != 0, 1);
                if (exp_b[i].size() != 0) chk("bresp", m_bresp[i], exp_b[i].pop_front());
            end
    end

    // Requester drivers: one burst at a time from req_q, random wvalid / bready gaps
    initial begin : req_drv
        int ph [2];
        int bt [2];
        burst_t hb;
        ph = '{0, 0};
        bt = '{0, 0};
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (!rst_n || req_q[i].size() == 0) begin
                    ph[i] = 0;
                    bt[i] = 0;
                end else if (ph[i] == 0 && fm_aw[i]) begin
                    ph[i] = 1;
                    bt[i] = 0;
                end else if (ph[i] == 1 && fm_w[i]) begin
                    if (bt[i] == req_q[i][0].nb - 1) ph[i] = 2;
                    else bt[i]++;
                end else if (ph[i] == 2 && fm_b[i]) begin
                    void'(req_q[i].pop_front());
                    ph[i] = 0;
                end
                if (!rst_n || req_q[i].size() == 0) begin
                    m_awvalid[i] = 1'b0;
                    m_wvalid[i]  = 1'b0;
                    m_wlast[i]   = 1'b0;
                    m_bready[i]  = 1'b0;
                end else begin
                    hb = req_q[i][0];
                    m_awvalid[i] = (ph[i] == 0);
                    m_awaddr[i]  = hb.addr;
                    m_awlen[i]   = hb.len;
                    m_wvalid[i]  = (ph[i] == 1) && ((m_wvalid[i] && !fm_w[i]) || $urandom_range(3) != 0);
                    m_wdata[i]   = data_of(hb.addr, bt[i]);
                    m_wstrb[i]   = strb_of(hb.addr, bt[i]);
                    m_wlast[i]   = (bt[i] == hb.nb - 1);
                    m_bready[i]  = (ph[i] == 2) && ($urandom_range(1) != 0);
                end
            end
        end
    end

    // DDR3 slave: random ready, answers each burst with the response queued at its AW handshake
    initial begin : ddr_drv
        int    sph;
        resp_t cur_r;
        sph = 0;
        cur_r = '{2'b00, '0};
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                sph = 0;
            end else begin
                if (sph == 1 && f_b) sph = 0;
                if (f_w && f_wl) begin
                    cur_r = (sl_q.size() != 0) ? sl_q.pop_front() : '{2'b00, '0};
                    sph = 1;
                end
            end
            s_awready = rst_n && ($urandom_range(1) != 0);
            s_wready  = rst_n && ($urandom_range(3) != 0);
            s_bvalid  = (sph == 1) && (s_bvalid || $urandom_range(1) != 0);
            s_bresp   = cur_r.bresp;
            s_bid     = cur_r.id;
        end
    end

    task automatic add(input int i, input logic [AW-1:0] a, input int len, input int nb, input logic [1:0] br);
        burst_t b;
        b.addr = a;
        b.len = 8'(len);
        b.nb = nb;
        b.bresp = br;
        b.id = i;
        st[i].push_back(b);
    endtask

    // Reference order: pending bursts are served one at a time; on a tie the one not served last goes
    task automatic release_all();
        @(negedge clk);
        while (st[0].size() != 0 || st[1].size() != 0) begin
            int p;
            burst_t b;
            p = (st[0].size() != 0 && st[1].size() != 0) ? 1 - last_srv : (st[0].size() != 0 ? 0 : 1);
            b = st[p].pop_front();
            exp_aw.push_back(b);
            for (int k = 0; k < b.nb; k++) exp_w.push_back('{data_of(b.addr, k), strb_of(b.addr, k), k == b.nb - 1});
            exp_b[p].push_back(b.bresp);
            req_q[p].push_back(b);
            if (b.nb != int'(b.len) + 1 || b.bresp != 2'b00) err_exp = 1'b1;
            last_srv = p;
        end
    endtask

    task automatic flush();
        exp_aw.delete();
        exp_w.delete();
        exp_b[0].delete();
        exp_b[1].delete();
        req_q[0].delete();
        req_q[1].delete();
        sl_q.delete();
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while ((exp_aw.size() + exp_w.size() + exp_b[0].size() + exp_b[1].size()) != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_done"}, n < 3000, 1);
        if (n >= 3000) flush();
        repeat (2) @(negedge clk);
        chk({nm, "_err"}, err_o, err_exp);
        chk({nm, "_nongranted_quiet"}, leak - leak_base, 0);
        leak_base = leak;
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_handshake_outs", {s_awvalid, s_wvalid, s_bready, m_awready, m_wready, m_bvalid}, 0);
        chk("rst_err", err_o, 0);
        chk("rst_awid", s_awid, 1);
        rst_n = 1'b1;
        calib = 1'b1;
        repeat (2) @(negedge clk);

        add(0, 32'h2000, 0, 1, 2'b00);
        add(1, 32'h3000, 0, 1, 2'b00);
        release_all();
        wait_done("tie");

        add(0, 32'h4000, 1, 2, 2'b00);
        add(0, 32'h4100, 2, 3, 2'b00);
        add(1, 32'h5000, 1, 2, 2'b00);
        add(1, 32'h5100, 0, 1, 2'b00);
        release_all();
        wait_done("alternate");

        add(0, 32'h1000, 3, 4, 2'b00);
        release_all();
        wait_done("single_m0");
        chk("single_aw_latency", aw_rise - req_rise, 1);

        calib = 1'b0;
        add(1, 32'h6000, 2, 3, 2'b00);
        release_all();
        repeat (10) @(negedge clk);
        t_cal = cyc;
        calib = 1'b1;
        wait_done("calib");
        chk("calib_aw_latency", aw_rise - t_cal, 1);

        add(0, 32'h7000, 3, 2, 2'b00);
        release_all();
        wait_done("early_wlast");
        add(1, 32'h7100, 1, 2, 2'b00);
        release_all();
        wait_done("after_err");
        add(0, 32'h7200, 0, 1, 2'b10);
        release_all();
        wait_done("bresp_err");

        add(0, 32'h8000, 7, 8, 2'b00);
        release_all();
        n = 0;
        while (exp_w.size() > 5 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("mid_burst_reached", n < 1000, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_handshake_outs", {s_awvalid, s_wvalid, s_bready, m_awready, m_wready, m_bvalid}, 0);
        chk("async_rst_err", err_o, 0);
        flush();
        last_srv = 1;
        err_exp = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        leak_base = leak;
        add(0, 32'h9000, 3, 4, 2'b00);
        release_all();
        wait_done("post_reset");

        for (int r = 0; r < 12; r++) begin
            int n0, n1, l;
            n0 = $urandom_range(3);
            n1 = $urandom_range(3);
            if (n0 + n1 == 0) n0 = 1;
            for (int k = 0; k < n0; k++) begin
                l = $urandom_range(7);
                add(0, $urandom & 32'hFFFF_FFC0, l, l + 1, 2'b00);
            end
            for (int k = 0; k < n1; k++) begin
                l = $urandom_range(7);
                add(1, $urandom & 32'hFFFF_FFC0, l, l + 1, 2'b00);
            end
            release_all();
            wait_done("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
